// File: rtl/sysbus_pkg.sv
// Shared types and constants for the two-master Sysbus arbiter.
// Tag layout: [12]=rw, [11:8]=type, [7:0]=id.
package sysbus_pkg;
   localparam int DATA_WIDTH = 64;
   localparam int TAG_WIDTH  = 13;
   localparam int TAG_RW_BIT = 12;

   localparam logic       RW_READ     = 1'b0;
   localparam logic       RW_WRITE    = 1'b1;
   localparam logic [3:0] TYPE_MEMORY = 4'h1;
   localparam logic [3:0] TYPE_MMIO   = 4'h2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_WDATA = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   function automatic logic tag_is_write(input logic [TAG_WIDTH-1:0] tag);
      return tag[TAG_RW_BIT] == RW_WRITE;
   endfunction
endpackage

// File: rtl/sysbus_if.sv
// One Sysbus port: request channel (reqcyc/req/reqtag, accepted by reqack)
// and response channel (respcyc/resp/resptag, accepted by respack).
interface sysbus_if;
   // Handshake: a beat transfers in a cycle where the sender's *cyc and the
   // receiver's *ack are both high; *cyc may not depend on the matching *ack.
   logic                             reqcyc;
   logic [sysbus_pkg::DATA_WIDTH-1:0] req;
   logic [sysbus_pkg::TAG_WIDTH-1:0]  reqtag;
   logic                             reqack;
   logic                             respcyc;
   logic [sysbus_pkg::DATA_WIDTH-1:0] resp;
   logic [sysbus_pkg::TAG_WIDTH-1:0]  resptag;
   logic                             respack;

   modport master (output reqcyc, req, reqtag, respack,
                   input  reqack, respcyc, resp, resptag);
   modport slave  (input  reqcyc, req, reqtag, respack,
                   output reqack, respcyc, resp, resptag);
endinterface

// File: rtl/sysbus_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to rr_ptr.
module sysbus_rr_pick (
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_rr_ptr,
   output logic o_vld,
   output logic o_idx
);
   assign o_vld = i_req0 | i_req1;
   assign o_idx = (i_req0 & i_req1) ? i_rr_ptr : i_req1;
endmodule

// File: rtl/sysbus_arbiter.sv
// Shares one Sysbus port between fetch (m0) and load/store (m1), one
// committed transaction at a time, with per-transaction handshake routing.
module sysbus_arbiter
   import sysbus_pkg::*;
#(
   parameter int BEATS   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       reset,
   sysbus_if.slave    m0,
   sysbus_if.slave    m1,
   sysbus_if.master   bus,
   output logic       owner,
   output logic       busy,
   output logic       err_timeout,
   output arb_state_e o_dbg_state
);
   localparam int CW = $clog2(BEATS) + 1;
   localparam int WW = $clog2(TIMEOUT) + 1;

   arb_state_e            r_state;
   logic                  r_owner;
   logic                  r_rr_ptr;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_addr;
   logic [TAG_WIDTH-1:0]  r_tag;
   logic [CW-1:0]         r_cnt;
   logic [WW-1:0]         r_wd;

   logic                  w_grant_vld;
   logic                  w_grant_idx;
   logic                  w_own_reqcyc;
   logic [DATA_WIDTH-1:0] w_own_req;
   logic [TAG_WIDTH-1:0]  w_own_reqtag;
   logic                  w_own_respack;
   logic                  w_wbeat;
   logic                  w_rbeat;
   logic                  w_last;
   logic                  w_progress;
   logic                  w_watched;

   sysbus_rr_pick u_pick (
      .i_req0   (m0.reqcyc),
      .i_req1   (m1.reqcyc),
      .i_rr_ptr (r_rr_ptr),
      .o_vld    (w_grant_vld),
      .o_idx    (w_grant_idx)
   );

   assign w_own_reqcyc  = r_owner ? m1.reqcyc  : m0.reqcyc;
   assign w_own_req     = r_owner ? m1.req     : m0.req;
   assign w_own_reqtag  = r_owner ? m1.reqtag  : m0.reqtag;
   assign w_own_respack = r_owner ? m1.respack : m0.respack;

   assign w_wbeat    = (r_state == ST_WDATA) && w_own_reqcyc;
   assign w_rbeat    = (r_state == ST_RESP) && bus.respcyc && w_own_respack;
   assign w_last     = (r_cnt == CW'(BEATS - 1));
   assign w_progress = ((r_state == ST_IDLE) && w_grant_vld) ||
                       ((r_state == ST_ADDR) && bus.reqack) || w_wbeat || w_rbeat;
   assign w_watched  = (r_state == ST_ADDR) || (r_state == ST_RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_owner  <= 1'b0;
         r_rr_ptr <= 1'b0;
         r_err    <= 1'b0;
         r_addr   <= '0;
         r_tag    <= '0;
         r_cnt    <= '0;
         r_wd     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_grant_vld) begin
               r_owner <= w_grant_idx;
               r_addr  <= w_grant_idx ? m1.req : m0.req;
               r_tag   <= w_grant_idx ? m1.reqtag : m0.reqtag;
               r_cnt   <= '0;
               r_state <= ST_ADDR;
            end
            ST_ADDR: if (bus.reqack) begin
               r_cnt   <= '0;
               r_state <= tag_is_write(r_tag) ? ST_WDATA : ST_RESP;
            end
            ST_WDATA: if (w_wbeat) begin
               if (w_last) begin
                  r_state  <= ST_IDLE;
                  r_rr_ptr <= ~r_owner;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_RESP: if (w_rbeat) begin
               if (w_last) begin
                  r_state  <= ST_IDLE;
                  r_rr_ptr <= ~r_owner;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Watchdog saturates at TIMEOUT; the flag is sticky and does not abort.
         if (w_progress || !w_watched) begin
            r_wd <= '0;
         end else if (r_wd != WW'(TIMEOUT)) begin
            r_wd <= r_wd + WW'(1);
            if (r_wd == WW'(TIMEOUT - 1)) r_err <= 1'b1;
         end
      end
   end

   assign owner       = r_owner;
   assign busy        = (r_state != ST_IDLE);
   assign err_timeout = r_err;
   assign o_dbg_state = r_state;

   always_comb begin
      bus.reqcyc  = 1'b0;
      bus.req     = '0;
      bus.reqtag  = '0;
      bus.respack = 1'b0;
      m0.reqack   = 1'b0;
      m0.respcyc  = 1'b0;
      m0.resp     = '0;
      m0.resptag  = '0;
      m1.reqack   = 1'b0;
      m1.respcyc  = 1'b0;
      m1.resp     = '0;
      m1.resptag  = '0;
      case (r_state)
         ST_ADDR: begin
            bus.reqcyc = 1'b1;
            bus.req    = r_addr;
            bus.reqtag = r_tag;
            if (r_owner) m1.reqack = bus.reqack;
            else         m0.reqack = bus.reqack;
         end
         ST_WDATA: begin
            bus.reqcyc = w_own_reqcyc;
            bus.req    = w_own_req;
            bus.reqtag = w_own_reqtag;
         end
         ST_RESP: begin
            bus.respack = w_own_respack;
            if (r_owner) begin
               m1.respcyc = bus.respcyc;
               m1.resp    = bus.resp;
               m1.resptag = bus.resptag;
            end else begin
               m0.respcyc = bus.respcyc;
               m0.resp    = bus.resp;
               m0.resptag = bus.resptag;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: reads, arbitration, writes,
// response backpressure, watchdog, mid-transaction reset, spurious responses.
module tb_sysbus_arbiter;
   import sysbus_pkg::*;

   localparam logic [12:0] TAG_R0 = {1'b0, 4'h1, 8'h11};
   localparam logic [12:0] TAG_R1 = {1'b0, 4'h2, 8'h22};
   localparam logic [12:0] TAG_W1 = {1'b1, 4'h1, 8'h33};

   logic       clk;
   logic       rst;
   logic       owner;
   logic       busy;
   logic       err_timeout;
   arb_state_e dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] exp_q[$];

   sysbus_if m0_if ();
   sysbus_if m1_if ();
   sysbus_if bus_if ();

   sysbus_arbiter #(.BEATS(8), .TIMEOUT(16)) dut (
      .clk         (clk),
      .reset       (rst),
      .m0          (m0_if),
      .m1          (m1_if),
      .bus         (bus_if),
      .owner       (owner),
      .busy        (busy),
      .err_timeout (err_timeout),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive_req(input logic mst, input logic cyc, input logic [63:0] a, input logic [12:0] t);
      if (mst) begin m1_if.reqcyc = cyc; m1_if.req = a; m1_if.reqtag = t; end
      else     begin m0_if.reqcyc = cyc; m0_if.req = a; m0_if.reqtag = t; end
   endtask

   task automatic set_respack(input logic mst, input logic v);
      if (mst) m1_if.respack = v;
      else     m0_if.respack = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_read(input logic mst, input logic [63:0] addr, input logic [12:0] tag,
                          input int ack_dly, input logic [7:0] stall);
      int   beat;
      int   guard;
      logic stalled;
      logic ack;
      drive_req(mst, 1'b1, addr, tag);
      #1 check("rd_pre_grant_reqcyc", bus_if.reqcyc, 0);
      @(negedge clk);
      drive_req(mst, 1'b0, 64'h0, 13'h0);
      #1;
      check("rd_addr_reqcyc", bus_if.reqcyc, 1);
      check("rd_addr_req", bus_if.req, addr);
      check("rd_addr_reqtag", bus_if.reqtag, tag);
      check("rd_addr_owner", owner, mst);
      check("rd_addr_busy", busy, 1);
      for (int i = 0; i < ack_dly; i++) begin
         check("rd_wait_reqack", mst ? m1_if.reqack : m0_if.reqack, 0);
         @(negedge clk);
      end
      bus_if.reqack = 1'b1;
      #1;
      check("rd_own_reqack", mst ? m1_if.reqack : m0_if.reqack, 1);
      check("rd_other_reqack", mst ? m0_if.reqack : m1_if.reqack, 0);
      @(negedge clk);
      bus_if.reqack = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back(addr + 64'(i));
      beat = 0; guard = 0; stalled = 1'b0;
      while (beat < 8 && guard < 40) begin
         ack = !(stall[beat] && !stalled);
         stalled = !ack;
         bus_if.respcyc = 1'b1;
         bus_if.resp    = addr + 64'(beat);
         bus_if.resptag = tag;
         set_respack(mst, ack);
         #1;
         check("rd_own_respcyc", mst ? m1_if.respcyc : m0_if.respcyc, 1);
         check("rd_own_resp", mst ? m1_if.resp : m0_if.resp, exp_q[0]);
         check("rd_own_resptag", mst ? m1_if.resptag : m0_if.resptag, tag);
         check("rd_bus_respack", bus_if.respack, ack);
         check("rd_other_respcyc", mst ? m0_if.respcyc : m1_if.respcyc, 0);
         check("rd_busy_in_resp", busy, 1);
         if (ack) begin
            void'(exp_q.pop_front());
            beat++;
         end
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) check("rd_beat_budget", 64'(beat), 8);
      exp_q.delete();
      bus_if.respcyc = 1'b0;
      set_respack(mst, 1'b0);
      #1 check("rd_idle_after", busy, 0);
   endtask

   task automatic do_write(input logic mst, input logic [63:0] addr, input logic [12:0] tag);
      int beat;
      int guard;
      drive_req(mst, 1'b1, addr, tag);
      #1 check("wr_pre_grant_reqcyc", bus_if.reqcyc, 0);
      @(negedge clk);
      drive_req(mst, 1'b0, 64'h0, 13'h0);
      bus_if.reqack = 1'b1;
      #1;
      check("wr_addr_req", bus_if.req, addr);
      check("wr_addr_reqtag", bus_if.reqtag, tag);
      check("wr_own_reqack", mst ? m1_if.reqack : m0_if.reqack, 1);
      @(negedge clk);
      bus_if.reqack = 1'b0;
      beat = 0; guard = 0;
      while (beat < 8 && guard < 20) begin
         if (guard == 3) begin
            drive_req(mst, 1'b0, 64'hFFFF, tag);
            #1;
            check("wr_gap_reqcyc", bus_if.reqcyc, 0);
            check("wr_gap_busy", busy, 1);
         end else begin
            drive_req(mst, 1'b1, 64'hA0 + 64'(beat), tag);
            #1;
            check("wr_data_reqcyc", bus_if.reqcyc, 1);
            check("wr_data_req", bus_if.req, 64'hA0 + 64'(beat));
            check("wr_data_reqtag", bus_if.reqtag, tag);
            check("wr_data_respack", bus_if.respack, 0);
            beat++;
         end
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) check("wr_beat_budget", 64'(beat), 8);
      drive_req(mst, 1'b0, 64'h0, 13'h0);
      #1;
      check("wr_idle_after", busy, 0);
      check("wr_no_resp_phase", bus_if.respack, 0);
   endtask

   initial begin
      rst = 1'b1;
      m0_if.reqcyc = 1'b0; m0_if.req = '0; m0_if.reqtag = '0; m0_if.respack = 1'b0;
      m1_if.reqcyc = 1'b0; m1_if.req = '0; m1_if.reqtag = '0; m1_if.respack = 1'b0;
      bus_if.reqack = 1'b0; bus_if.respcyc = 1'b0; bus_if.resp = '0; bus_if.resptag = '0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_owner", owner, 0);
      check("rst_err", err_timeout, 0);
      check("rst_bus_reqcyc", bus_if.reqcyc, 0);
      check("rst_bus_respack", bus_if.respack, 0);
      check("rst_m0_reqack", m0_if.reqack, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // m0 read alone, address accepted two cycles into ADDR
      do_read(1'b0, 64'h1000, TAG_R0, 2, 8'h00);

      // simultaneous requests after reset: m0 first, m1 on the following IDLE cycle
      do_reset();
      drive_req(1'b1, 1'b1, 64'h1200, TAG_R1);
      do_read(1'b0, 64'h1100, TAG_R0, 0, 8'h00);
      do_read(1'b1, 64'h1200, TAG_R1, 1, 8'h00);

      // m1 write with one idle gap in the data stream
      do_write(1'b1, 64'h2000, TAG_W1);

      // spurious response while idle
      @(negedge clk);
      bus_if.respcyc = 1'b1; bus_if.resp = 64'h55; bus_if.resptag = TAG_R0;
      m0_if.respack = 1'b1; m1_if.respack = 1'b1;
      #1;
      check("spur_bus_respack", bus_if.respack, 0);
      check("spur_m0_respcyc", m0_if.respcyc, 0);
      check("spur_m1_respcyc", m1_if.respcyc, 0);
      @(negedge clk);
      bus_if.respcyc = 1'b0; m0_if.respack = 1'b0; m1_if.respack = 1'b0;
      #1 check("spur_still_idle", busy, 0);

      // backpressure on the 3rd and 4th response beats
      do_read(1'b0, 64'h3000, TAG_R0, 1, 8'b0000_1100);

      // watchdog: address never accepted
      do_reset();
      drive_req(1'b1, 1'b1, 64'h4000, TAG_R1);
      @(negedge clk);
      drive_req(1'b1, 1'b0, 64'h0, 13'h0);
      for (int k = 1; k <= 16; k++) begin
         #1;
         if (k == 16) check("wd_err_before", err_timeout, 0);
         @(negedge clk);
      end
      #1 check("wd_err_set", err_timeout, 1);
      for (int k = 0; k < 3; k++) @(negedge clk);
      #1;
      check("wd_err_sticky", err_timeout, 1);
      check("wd_still_addr", bus_if.reqcyc, 1);
      check("wd_owner", owner, 1);
      bus_if.reqack = 1'b1;
      @(negedge clk);
      bus_if.reqack = 1'b0;
      bus_if.respcyc = 1'b1; bus_if.resp = 64'h77; bus_if.resptag = TAG_R1;
      m1_if.respack = 1'b1;
      for (int k = 0; k < 3; k++) @(negedge clk);
      #1;
      check("wd_err_in_resp", err_timeout, 1);
      check("mid_resp_m1_respcyc", m1_if.respcyc, 1);
      // asynchronous reset in the middle of the response phase
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_owner", owner, 0);
      check("arst_err", err_timeout, 0);
      check("arst_bus_respack", bus_if.respack, 0);
      check("arst_m1_respcyc", m1_if.respcyc, 0);
      check("arst_bus_reqcyc", bus_if.reqcyc, 0);
      @(negedge clk);
      bus_if.respcyc = 1'b0; m1_if.respack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1 check("arst_release_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "bench time limit reached");
   end
endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
Two-master arbiter that shares the single Sysbus port between the instruction fetch unit (master 0) and the data/load-store unit (master 1).
It grants one transaction at a time with round-robin priority, then sequences the address phase, write-data beats and read-response beats for that transaction.
During a transaction it routes the bus handshakes to and from the owning master only.
It sits between the core's fetch/data units and the top-level Sysbus.

Parameters:
DATA_WIDTH, 64, width of req/resp data and address
TAG_WIDTH, 13, reqtag/resptag width: [12]=rw (1=WRITE, 0=READ), [11:8]=type, [7:0]=id
BEATS, 8, data beats per transaction (one 64-byte line)
TIMEOUT, 1024, cycles without progress in ADDR/RESP before err_timeout sets

Ports:
clk  in  1  bus clock
reset  in  1  asynchronous, active-high reset
m0_reqcyc / m1_reqcyc  in  1  master request valid
m0_req / m1_req  in  DATA_WIDTH  address (ADDR phase) or write data (WDATA phase)
m0_reqtag / m1_reqtag  in  TAG_WIDTH  request tag
m0_reqack / m1_reqack  out  1  address accepted
m0_respcyc / m1_respcyc  out  1  response beat valid
m0_resp / m1_resp  out  DATA_WIDTH  response data
m0_resptag / m1_resptag  out  TAG_WIDTH  response tag
m0_respack / m1_respack  in  1  master accepts response beat
bus_reqcyc  out  1  Sysbus request valid
bus_req  out  DATA_WIDTH  Sysbus request address/data
bus_reqtag  out  TAG_WIDTH  Sysbus request tag
bus_reqack  in  1  Sysbus address accept
bus_respcyc  in  1  Sysbus response valid
bus_resp  in  DATA_WIDTH  Sysbus response data
bus_resptag  in  TAG_WIDTH  Sysbus response tag
bus_respack  out  1  response beat accepted
owner  out  1  master currently granted (valid when busy)
busy  out  1  state != IDLE
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction): state IDLE, rr_ptr=0, owner=0, beat count=0, watchdog=0, err_timeout=0. All outputs are 0.
- States: IDLE, ADDR, WDATA, RESP.
- IDLE:
  - If only one master has reqcyc=1, grant it.
  - If both, grant rr_ptr.
  - On grant: latch owner, m_req, m_reqtag; go to ADDR at the next edge. bus_reqcyc rises 1 cycle after the master's reqcyc is sampled.
- ADDR:
  - bus_reqcyc=1; bus_req and bus_reqtag come from the latched values and are held stable.
  - m{owner}_reqack = bus_reqack (combinational). The non-owner's reqack stays 0.
  - On bus_reqack: if tag[12]=1, go to WDATA with count=0; else go to RESP with count=0.
  - Owner dropping reqcyc after grant is ignored; a granted transaction is committed.
- WDATA:
  - bus_reqcyc, bus_req and bus_reqtag are combinational pass-through of the owner's inputs.
  - Each cycle with owner reqcyc=1 counts one beat.
  - After beat BEATS: go to IDLE and set rr_ptr=~owner. No response phase for writes.
- RESP:
  - m{owner}_respcyc/resp/resptag = bus_respcyc/resp/resptag. bus_respack = m{owner}_respack.
  - Beat counts when bus_respcyc && bus_respack.
  - On the BEATS-th beat: go to IDLE and set rr_ptr=~owner.
  - The non-owner's respcyc stays 0. A bus_respcyc arriving in IDLE/ADDR/WDATA is not acked (bus_respack=0).
- Back-to-back: the cycle after returning to IDLE can grant again. Minimum gap between transactions is 1 IDLE cycle.
- Counter widths:
  - Beat counter is clog2(BEATS)+1 bits.
  - Watchdog is clog2(TIMEOUT)+1 bits. It clears on any state change or beat, and increments in ADDR/RESP otherwise.
  - When the watchdog reaches TIMEOUT, err_timeout=1 (sticky until reset). The state machine remains in its state.
- Tags pass through unmodified. Routing uses the owner register only, since there is a single outstanding transaction.

Decomposition:
- Package sysbus_pkg: DATA_WIDTH, TAG_WIDTH, READ/WRITE rw encodings, MEMORY/MMIO type codes, arbiter state enum.
- Sub-module sysbus_rr_pick: 2-way round-robin grant from two requests and rr_ptr; returns grant valid and index.
- Main module holds the FSM, latches, counters and routing mux.

Test Plan:
- m0 read 0x1000 alone; bus acks 2 cycles later, then 8 resp beats with respack=1 -> bus_req=0x1000, m0_reqack pulses once, m0 receives 8 beats, m1_respcyc=0 throughout, busy falls after beat 8.
- m0 and m1 request reads in the same cycle after reset -> m0 granted first (rr_ptr=0). m1 granted on the IDLE cycle following m0's 8th beat.
- m1 write 0x2000 with 8 data beats 0xA0..0xA7 -> bus sees addr 0x2000 with tag[12]=1, then 0xA0..0xA7 on bus_req, then IDLE with no response phase.
- Response backpressure: m0_respack low on beats 3 and 4 -> bus_respack low those cycles; exactly 8 accepted beats; no early return to IDLE.
- bus_reqack never asserted for TIMEOUT=16 -> err_timeout=1 at cycle 16 of ADDR and stays set. Reset asserted mid-RESP -> all outputs 0 immediately, err_timeout cleared.
- Spurious bus_respcyc in IDLE -> bus_respack=0, m0/m1 respcyc=0.
